i2c_master_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer sharing one I2C master core between two requesters. Captures a requester's transaction fields, drives the master's command inputs and Start handshake, and tracks Ready through the transfer. Returns completion, error and read data to the winner. Sits between the system-side clients and the I2C master core, replacing the stimulus-driven control of that core.

---
 rtl/i2c_arb_pkg.sv | 25 ++
 rtl/i2c_master_arbiter_rr_arb2.sv | 32 +++
 rtl/i2c_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and widths for the two-client
// I2C master arbiter.
package i2c_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADR_W   = 7;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [BYTE_W-1:0] pointer;
    logic              set_pointer;
    logic [BYTE_W-1:0] data_in;
    logic [BYTE_W-1:0] data_in2;
    logic              r_w;
  } fields_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; combinational grant,
// priority register flips to the loser whenever a grant is taken.
module rr_arb2
  import i2c_arb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_take,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic r_prio;

  always_comb begin
    o_gnt = '0;
    if (i_req[0] && (!r_prio || !i_req[1])) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_take && (|o_gnt)) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one I2C master core between two clients,
// sequencing Start/Ready and returning status and read data.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [ADR_W-1:0]  i_adr0,
  input  logic [BYTE_W-1:0] i_pointer0,
  input  logic              i_set_pointer0,
  input  logic [BYTE_W-1:0] i_data_in0,
  input  logic [BYTE_W-1:0] i_data_in2_0,
  input  logic              i_r_w0,
  input  logic              i_req1,
  input  logic [ADR_W-1:0]  i_adr1,
  input  logic [BYTE_W-1:0] i_pointer1,
  input  logic              i_set_pointer1,
  input  logic [BYTE_W-1:0] i_data_in1,
  input  logic [BYTE_W-1:0] i_data_in2_1,
  input  logic              i_r_w1,
  output logic              o_gnt0,
  output logic              o_done0,
  output logic              o_err0,
  output logic [15:0]       o_rd_data0,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic              o_err1,
  output logic [15:0]       o_rd_data1,
  output logic [ADR_W-1:0]  o_adr,
  output logic [BYTE_W-1:0] o_pointer,
  output logic              o_set_pointer,
  output logic [BYTE_W-1:0] o_data_in,
  output logic [BYTE_W-1:0] o_data_in2,
  output logic              o_r_w,
  output logic              o_start,
  input  logic              i_ready,
  input  logic              i_error,
  input  logic [BYTE_W-1:0] i_data_out,
  input  logic [BYTE_W-1:0] i_data_out2
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  fields_t              w_f0;
  fields_t              w_f1;
  fields_t              r_f;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_err;
  logic [15:0]          r_rd0;
  logic [15:0]          r_rd1;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_own;
  logic                 r_start;
  logic                 w_take;
  logic                 w_tmo;
  logic                 w_fin;

  assign w_f0 = {i_adr0, i_pointer0, i_set_pointer0,
                 i_data_in0, i_data_in2_0, i_r_w0};
  assign w_f1 = {i_adr1, i_pointer1, i_set_pointer1,
                 i_data_in1, i_data_in2_1, i_r_w1};

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_req1, i_req0}),
    .i_take  (w_take),
    .o_gnt   (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_tmo       = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_ready && (i_req0 || i_req1)) begin
          w_take      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!i_ready) begin
          w_state_nxt = BUSY;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      BUSY: begin
        if (i_ready) begin
          w_fin       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_f     <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
      r_cnt   <= '0;
      r_own   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      r_err   <= '0;
      if (w_take) begin
        r_f     <= w_gnt[1] ? w_f1 : w_f0;
        r_own   <= w_gnt[1];
        r_gnt   <= w_gnt;
        r_start <= 1'b1;
        r_cnt   <= '0;
      end
      if (r_state == START) begin
        if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        if (!i_ready || w_tmo) r_start <= 1'b0;
      end
      // timeout reports as an error without touching read data
      if (w_tmo) begin
        r_done[r_own] <= 1'b1;
        r_err[r_own]  <= 1'b1;
      end
      if (w_fin) begin
        r_done[r_own] <= 1'b1;
        r_err[r_own]  <= i_error;
        if (r_f.r_w && !i_error) begin
          if (r_own) r_rd1 <= {i_data_out2, i_data_out};
          else       r_rd0 <= {i_data_out2, i_data_out};
        end
      end
      if (r_state == DONE) r_gnt <= '0;
    end
  end

  assign {o_adr, o_pointer, o_set_pointer,
          o_data_in, o_data_in2, o_r_w} = r_f;
  assign o_start    = r_start;
  assign o_gnt0     = r_gnt[0];
  assign o_gnt1     = r_gnt[1];
  assign o_done0    = r_done[0];
  assign o_done1    = r_done[1];
  assign o_err0     = r_err[0];
  assign o_err1     = r_err[1];
  assign o_rd_data0 = r_rd0;
  assign o_rd_data1 = r_rd1;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: scoreboard bench with a scripted master
// model driving Ready/Error/Data_out against the arbiter.
module tb_i2c_master_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0, req1, sp0, sp1, rw0, rw1;
  logic [6:0] adr0, adr1;
  logic [7:0] ptr0, ptr1, di0, di1, di20, di21;
  logic gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] rd0, rd1;
  logic [6:0] m_adr;
  logic [7:0] m_ptr, m_di, m_di2;
  logic m_sp, m_rw, start;
  logic ready, error;
  logic [7:0] dout, dout2;
  logic [32:0] m_f;

  assign m_f = {m_adr, m_ptr, m_sp, m_di, m_di2, m_rw};

  typedef struct packed {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } resp_t;

  resp_t sb[$];
  logic [15:0] e_rd0, e_rd1;
  int n_checks = 0;
  int n_fail = 0;

  i2c_master_arbiter #(.TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_adr0(adr0), .i_pointer0(ptr0),
    .i_set_pointer0(sp0), .i_data_in0(di0), .i_data_in2_0(di20),
    .i_r_w0(rw0),
    .i_req1(req1), .i_adr1(adr1), .i_pointer1(ptr1),
    .i_set_pointer1(sp1), .i_data_in1(di1), .i_data_in2_1(di21),
    .i_r_w1(rw1),
    .o_gnt0(gnt0), .o_done0(done0), .o_err0(err0), .o_rd_data0(rd0),
    .o_gnt1(gnt1), .o_done1(done1), .o_err1(err1), .o_rd_data1(rd1),
    .o_adr(m_adr), .o_pointer(m_ptr), .o_set_pointer(m_sp),
    .o_data_in(m_di), .o_data_in2(m_di2), .o_r_w(m_rw),
    .o_start(start), .i_ready(ready), .i_error(error),
    .i_data_out(dout), .i_data_out2(dout2)
  );

  // master model: Ready falls 'drop' cycles after Start is seen,
  // stays low 'busy' cycles; drop<0 means Ready never falls
  task automatic serve(input int drop, input int busy, input logic er,
                       input logic [7:0] b1, input logic [7:0] b2,
                       input bit rel, output int hi,
                       output logic [1:0] g, output logic [32:0] f);
    hi = -1;
    g = '0;
    f = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (start) break;
    end
    if (!start) return;
    hi = 1;
    g = {gnt1, gnt0};
    f = m_f;
    if (rel) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    if (drop < 0) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (!start) break;
        hi++;
      end
      return;
    end
    for (int c = 0; c < drop; c++) begin
      @(negedge clk);
      if (start) hi++;
    end
    ready = 1'b0;
    for (int c = 0; c < busy; c++) begin
      @(negedge clk);
      if (start) hi++;
      if (c == 0) error = er;
    end
    dout = b1;
    dout2 = b2;
    ready = 1'b1;
  endtask

  task automatic wait_done(output bit hit, output resp_t r,
                           output logic [1:0] g);
    hit = 1'b0;
    r = '0;
    g = '0;
    for (int i = 0; i < 30; i++) begin
      if (done0 | done1) begin
        hit = 1'b1;
        r = {done1, done0, err1, err0, rd0, rd1};
        g = {gnt1, gnt0};
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {req0, req1, sp0, sp1, rw0, rw1} = '0;
    {adr0, adr1, ptr0, ptr1, di0, di1, di20, di21} = '0;
    ready = 1'b1;
    error = 1'b0;
    dout = '0;
    dout2 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, rd0, rd1, m_f, start}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {gnt0, gnt1, done0, done1, err0, err1, rd0, rd1, m_f, start});
    end
    rst_n = 1'b1;
    e_rd0 = '0;
    e_rd1 = '0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    adr0 = 7'h4D; ptr0 = 8'h01; sp0 = 1'b0;
    di0 = 8'h99; di20 = 8'h5A; rw0 = 1'b0;
    req0 = 1'b1;
    sb.push_back({2'b01, 2'b00, e_rd0, e_rd1});
    serve(3, 2, 1'b0, 8'hEE, 8'hDD, 1'b1, hi, g, f);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL write_gnt: got %b want 01", g);
    end
    n_checks++;
    if (f !== {7'h4D, 8'h01, 1'b0, 8'h99, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL write_fields: got %h want %h", f,
               {7'h4D, 8'h01, 1'b0, 8'h99, 8'h5A, 1'b0});
    end
    n_checks++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL write_start_len: got %0d want 4", hi);
    end
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e || g !== 2'b01) begin
      n_fail++;
      $display("FAIL write_done: got %h gnt=%b hit=%0d want %h gnt=01",
               r, g, hit, e);
    end
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0, done1, done0} !== 4'b0) begin
      n_fail++;
      $display("FAIL write_release: got %b want 0000",
               {gnt1, gnt0, done1, done0});
    end
  endtask

  task automatic test_rr();
    int hi;
    logic [1:0] g, ge;
    logic [32:0] f, fe;
    bit hit;
    resp_t r, e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e_rd0 = '0;
    e_rd1 = '0;
    adr0 = 7'h10; ptr0 = 8'h20; sp0 = 1'b0;
    di0 = 8'h30; di20 = 8'h40; rw0 = 1'b0;
    adr1 = 7'h51; ptr1 = 8'h61; sp1 = 1'b1;
    di1 = 8'h71; di21 = 8'h81; rw1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ge = k[0] ? 2'b10 : 2'b01;
      fe = k[0] ? {7'h51, 8'h61, 1'b1, 8'h71, 8'h81, 1'b0}
                : {7'h10, 8'h20, 1'b0, 8'h30, 8'h40, 1'b0};
      sb.push_back({ge, 2'b00, e_rd0, e_rd1});
      serve(2, 1, 1'b0, 8'h00, 8'h00, 1'b0, hi, g, f);
      n_checks++;
      if (g !== ge || f !== fe) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b/%h want %b/%h", k, g, f, ge, fe);
      end
      wait_done(hit, r, g);
      e = sb.pop_front();
      n_checks++;
      if (!hit || r !== e || g !== ge) begin
        n_fail++;
        $display("FAIL rr_done%0d: got %h gnt=%b want %h gnt=%b",
                 k, r, g, e, ge);
      end
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0, done1, done0} !== 4'b0) begin
        n_fail++;
        $display("FAIL rr_gap%0d: got %b want 0000", k,
                 {gnt1, gnt0, done1, done0});
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_ready_low();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    @(negedge clk);
    ready = 1'b0;
    rw0 = 1'b0;
    req0 = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0, start} !== 3'b0) begin
      n_fail++;
      $display("FAIL ready_low_nogrant: got %b want 000",
               {gnt1, gnt0, start});
    end
    ready = 1'b1;
    sb.push_back({2'b01, 2'b00, e_rd0, e_rd1});
    serve(1, 1, 1'b0, 8'h00, 8'h00, 1'b1, hi, g, f);
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e) begin
      n_fail++;
      $display("FAIL ready_low_done: got %h want %h hit=%0d", r, e, hit);
    end
    @(negedge clk);
  endtask

  task automatic test_read();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    rw0 = 1'b1;
    req0 = 1'b1;
    e_rd0 = 16'h2211;
    sb.push_back({2'b01, 2'b00, e_rd0, e_rd1});
    serve(1, 2, 1'b0, 8'h11, 8'h22, 1'b1, hi, g, f);
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e) begin
      n_fail++;
      $display("FAIL read0_done: got %h want %h hit=%0d", r, e, hit);
    end
    @(negedge clk);
    rw1 = 1'b1;
    req1 = 1'b1;
    e_rd1 = 16'h3CA5;
    sb.push_back({2'b10, 2'b00, e_rd0, e_rd1});
    serve(2, 3, 1'b0, 8'hA5, 8'h3C, 1'b1, hi, g, f);
    n_checks++;
    if (g !== 2'b10 || f[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL read1_grant: got %b rw=%b want 10 rw=1", g, f[0]);
    end
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e) begin
      n_fail++;
      $display("FAIL read1_done: got %h want %h hit=%0d", r, e, hit);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    rw0 = 1'b1;
    req0 = 1'b1;
    dout = 8'hFF;
    dout2 = 8'hFF;
    sb.push_back({2'b01, 2'b01, e_rd0, e_rd1});
    serve(-1, 0, 1'b0, 8'h00, 8'h00, 1'b1, hi, g, f);
    n_checks++;
    if (hi !== 16) begin
      n_fail++;
      $display("FAIL timeout_start_len: got %0d want 16", hi);
    end
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e || start !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: got %h start=%b want %h start=0",
               r, start, e);
    end
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0, done1, done0, start} !== 5'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got %b want 00000",
               {gnt1, gnt0, done1, done0, start});
    end
  endtask

  task automatic test_error();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    rw1 = 1'b1;
    req1 = 1'b1;
    sb.push_back({2'b10, 2'b10, e_rd0, e_rd1});
    serve(1, 3, 1'b1, 8'h77, 8'h66, 1'b1, hi, g, f);
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e) begin
      n_fail++;
      $display("FAIL error_done: got %h want %h hit=%0d", r, e, hit);
    end
    error = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int hi;
    logic [1:0] g;
    logic [32:0] f;
    bit hit;
    resp_t r, e;
    bit seen;
    rw0 = 1'b0;
    req0 = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt1, gnt0, start, done1, done0} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %b want 00000",
               {gnt1, gnt0, start, done1, done0});
    end
    repeat (2) begin
      @(negedge clk);
      if (done0 | done1) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (done0 | done1) seen = 1'b1;
      if (i == 0) @(negedge clk);
    end
    e_rd0 = '0;
    e_rd1 = '0;
    sb.push_back({2'b01, 2'b00, e_rd0, e_rd1});
    serve(1, 1, 1'b0, 8'h00, 8'h00, 1'b1, hi, g, f);
    n_checks++;
    if (seen || g !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: got done_seen=%0d gnt=%b want 0/01",
               seen, g);
    end
    wait_done(hit, r, g);
    e = sb.pop_front();
    n_checks++;
    if (!hit || r !== e) begin
      n_fail++;
      $display("FAIL rst_mid_done: got %h want %h hit=%0d", r, e, hit);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_rr();
    test_ready_low();
    test_read();
    test_timeout();
    test_error();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
